cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Round-robin scheduler sharing the N_CDB common-data-bus writeback slots among the N_REQ functional-unit result ports (ALUs first, then MULs).
Grants up to N_CDB results per cycle and registers them onto the CDB.
The ROB uses the registered CDB to set commit flags; the physical register file uses it for writeback.
Guarantees starvation freedom, so no FU result can block ROB head commit indefinitely.

Parameters:
N_REQ, 4, number of FU result requesters (N_ALU + N_MUL)
N_CDB, 2, number of CDB slots per cycle (1 <= N_CDB <= N_REQ)
ROB_DEPTH, 8, ROB entries; ROB_W = $clog2(ROB_DEPTH)
PR_W, 6, physical register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush; discard this cycle's grants and clear CDB next cycle
req_valid  in  [N_REQ]  FU result valid
req_rob_id  in  [N_REQ][ROB_W]  ROB index of result
req_pd  in  [N_REQ][PR_W]  destination physical register
req_data  in  [N_REQ][32]  result value
req_ready  out  [N_REQ]  grant; transfer occurs when req_valid && req_ready
cdb_valid  out  [N_CDB]  CDB slot valid
cdb_rob_id  out  [N_CDB][ROB_W]  ROB index broadcast
cdb_pd  out  [N_CDB][PR_W]  physical register broadcast
cdb_data  out  [N_CDB][32]  value broadcast

Behaviour:
- Reset: rr_ptr=0; cdb_valid all 0; cdb_rob_id/pd/data all 0; req_ready all 0 while rst high.
- Handshake: requester holds req_valid and its payload stable until transfer. Transfer is req_valid && req_ready in the same cycle.
- req_ready is combinational from req_valid, rr_ptr, flush and rst. It is never asserted for an invalid requester.
- Selection: scan requesters in order rr_ptr, rr_ptr+1, ... mod N_REQ. The first min(N_CDB, #valid) valid requesters get ready.
- The k-th granted requester in scan order maps to CDB slot k. Slots beyond the grant count have cdb_valid=0 next cycle.
- Latency: 1 cycle. A payload transferred at edge t appears on cdb_* for exactly the cycle after edge t. The CDB has no backpressure.
- Pointer update:
  - At least one grant: rr_ptr <= (index of last granted requester + 1) mod N_REQ.
  - Zero grants: rr_ptr unchanged.
  - Wrap-around from N_REQ-1 to 0 is required.
- Fairness: a requester holding valid is granted within ceil(N_REQ/N_CDB) cycles.
- All requesters valid with N_CDB=N_REQ: all granted every cycle.
- Flush:
  - Same cycle: req_ready all 0, so no transfers.
  - Next cycle: cdb_valid all 0.
  - rr_ptr unchanged.
- rst and flush both high: rst dominates.
- Reset mid-stream: registered CDB contents are dropped. Requesters re-present after reset.
- Duplicate rob_id across requesters is not checked. Slot order conveys no priority to consumers.
- Assertions:
  - req_ready implies req_valid.
  - popcount(req_ready) <= N_CDB.
  - A valid requester is not un-granted beyond the fairness bound.

Decomposition:
- Shared package:
  - cdb_entry_t struct {valid, rob_id[ROB_W], pd[PR_W], data[32]}.
  - Constants N_CDB and N_REQ = N_ALU + N_MUL.
  - cdb_t redefined as cdb_entry_t [N_CDB], consumed by ROB and regfile.
- Sub-module rr_multi_picker: combinational rotating-priority picker. Takes a request vector and a pointer. Returns the grant vector, per-slot requester index, and next-pointer value.
- cdb_arbiter holds rr_ptr, the output registers and the flush/reset gating.

Test Plan:
(All with N_REQ=4, N_CDB=2.)
1. Reset, then req_valid=0000 -> cdb_valid=00, rr_ptr=0, req_ready=0000 for 3 cycles.
2. rr_ptr=0, req_valid=1111 held for 2 cycles ->
   - cycle 1: ready=0011, next cycle CDB slots carry req 0 then req 1.
   - cycle 2: ready=1100, next CDB carries req 2 then req 3; rr_ptr=0.
3. rr_ptr=3, req_valid=1001, req3 rob_id=5, req0 rob_id=2 -> ready=1001; next cycle slot0 rob_id=5, slot1 rob_id=2; rr_ptr=1.
4. Single req 2 valid with data=0xDEADBEEF, pd=17 -> ready=0100; next cycle cdb_valid=01, cdb_pd[0]=17, cdb_data[0]=0xDEADBEEF.
5. req_valid=1111 with flush=1 for one cycle -> ready=0000; next cycle cdb_valid=00; rr_ptr unchanged. Following cycle grants resume from the same pointer.
6. req_valid=1111 held for 10 cycles, random stalls on req 1 -> every requester granted at least once per 2 consecutive active cycles, and no grant to an invalid requester.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and sizing for the writeback arbiter, ROB and regfile.
package cdb_arbiter_pkg;
  localparam int N_ALU     = 2;
  localparam int N_MUL     = 2;
  localparam int N_REQ     = N_ALU + N_MUL;
  localparam int N_CDB     = 2;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_W     = $clog2(ROB_DEPTH);
  localparam int PR_W      = 6;
  localparam int REQ_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Worst-case wait, in cycles, before a held request is granted.
  localparam int FAIR      = (N_REQ + N_CDB - 1) / N_CDB;

  typedef logic [REQ_W-1:0] req_idx_t;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] rob_id;
    logic [PR_W-1:0]  pd;
    logic [31:0]      data;
  } cdb_entry_t;

  typedef cdb_entry_t [N_CDB-1:0] cdb_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result request bus plus registered CDB broadcast.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][ROB_W-1:0]  req_rob_id;
  logic [N_REQ-1:0][PR_W-1:0]   req_pd;
  logic [N_REQ-1:0][31:0]       req_data;
  logic [N_REQ-1:0]             req_ready;
  logic [N_CDB-1:0]             cdb_valid;
  logic [N_CDB-1:0][ROB_W-1:0]  cdb_rob_id;
  logic [N_CDB-1:0][PR_W-1:0]   cdb_pd;
  logic [N_CDB-1:0][31:0]       cdb_data;

  modport slave (
    input  req_valid, req_rob_id, req_pd, req_data,
    output req_ready, cdb_valid, cdb_rob_id, cdb_pd, cdb_data
  );

  modport master (
    output req_valid, req_rob_id, req_pd, req_data,
    input  req_ready, cdb_valid, cdb_rob_id, cdb_pd, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter_rr_multi_picker.sv
// Rotating-priority picker: first N_CDB set requests from i_ptr onward, in scan order.
module rr_multi_picker
  import cdb_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0]            i_req,
  input  req_idx_t                    i_ptr,
  output logic [N_REQ-1:0]            o_gnt,
  output req_idx_t [N_CDB-1:0]        o_slot_idx,
  output logic [N_CDB-1:0]            o_slot_vld,
  output req_idx_t                    o_next_ptr
);
  always_comb begin
    int       w_idx;
    int       w_cnt;
    req_idx_t w_ri;
    o_gnt      = '0;
    o_slot_idx = '0;
    o_slot_vld = '0;
    o_next_ptr = i_ptr;
    w_idx      = 0;
    w_cnt      = 0;
    w_ri       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      w_ri = req_idx_t'(w_idx);
      if (i_req[w_ri] && (w_cnt < N_CDB)) begin
        o_gnt[w_ri] = 1'b1;
        // The k-th grant in scan order lands on CDB slot k.
        for (int s = 0; s < N_CDB; s++) begin
          if (s == w_cnt) begin
            o_slot_idx[s] = w_ri;
            o_slot_vld[s] = 1'b1;
          end
        end
        o_next_ptr = (w_idx == N_REQ - 1) ? '0 : req_idx_t'(w_idx + 1);
        w_cnt      = w_cnt + 1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB writeback arbiter: grants up to N_CDB FU results per cycle, registered onto the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  req_idx_t             r_rr_ptr;
  cdb_t                 r_cdb;
  cdb_t                 w_cdb_nxt;
  logic [N_REQ-1:0]     w_gnt;
  req_idx_t [N_CDB-1:0] w_slot_idx;
  logic [N_CDB-1:0]     w_slot_vld;
  req_idx_t             w_next_ptr;
  logic                 w_en;

  rr_multi_picker u_pick (
    .i_req      (bus.req_valid),
    .i_ptr      (r_rr_ptr),
    .o_gnt      (w_gnt),
    .o_slot_idx (w_slot_idx),
    .o_slot_vld (w_slot_vld),
    .o_next_ptr (w_next_ptr)
  );

  assign w_en          = !rst && !flush;
  assign bus.req_ready = w_en ? w_gnt : '0;

  always_comb begin
    w_cdb_nxt = '0;
    for (int s = 0; s < N_CDB; s++) begin
      if (w_slot_vld[s]) begin
        w_cdb_nxt[s].valid  = 1'b1;
        w_cdb_nxt[s].rob_id = bus.req_rob_id[w_slot_idx[s]];
        w_cdb_nxt[s].pd     = bus.req_pd[w_slot_idx[s]];
        w_cdb_nxt[s].data   = bus.req_data[w_slot_idx[s]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_cdb    <= '0;
    end else if (flush) begin
      r_cdb    <= '0;
    end else begin
      r_cdb    <= w_cdb_nxt;
      if (|w_gnt) r_rr_ptr <= w_next_ptr;
    end
  end

  always_comb begin
    bus.cdb_valid  = '0;
    bus.cdb_rob_id = '0;
    bus.cdb_pd     = '0;
    bus.cdb_data   = '0;
    for (int s = 0; s < N_CDB; s++) begin
      bus.cdb_valid[s]  = r_cdb[s].valid;
      bus.cdb_rob_id[s] = r_cdb[s].rob_id;
      bus.cdb_pd[s]     = r_cdb[s].pd;
      bus.cdb_data[s]   = r_cdb[s].data;
    end
  end

`ifndef SYNTHESIS
  localparam int FW = $clog2(FAIR + 1);
  logic [N_REQ-1:0][FW-1:0] r_wait;

  // Consecutive cycles each requester sat valid but ungranted; flush cycles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
    end else if (!flush) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (bus.req_valid[r] && !bus.req_ready[r]) begin
          assert (int'(r_wait[r]) + 1 < FAIR);
          r_wait[r] <= r_wait[r] + FW'(1);
        end else begin
          r_wait[r] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((bus.req_ready & ~bus.req_valid) == '0);
      assert ($countones(bus.req_ready) <= N_CDB);
    end
  end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter with N_REQ=4, N_CDB=2.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_fail;

  cdb_arbiter_if bif ();

  cdb_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1; outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_payloads();
    for (int i = 0; i < N_REQ; i++) begin
      bif.req_rob_id[i] = ROB_W'(i + 1);
      bif.req_pd[i]     = PR_W'(10 + i);
      bif.req_data[i]   = 32'h1000_0000 + 32'(i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; bif.req_valid = 4'b1111; set_payloads();
    tick(); tick();
    n_checks++;
    if (bif.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got=%b exp=0000", bif.req_ready); end
    n_checks++;
    if (bif.cdb_valid !== 2'b00 || bif.cdb_data[0] !== 32'h0 || bif.cdb_rob_id[1] !== '0)
      begin n_fail++; $display("FAIL rst_cdb got v=%b d0=%h exp v=00 d0=0", bif.cdb_valid, bif.cdb_data[0]); end
    rst = 1'b0; flush = 1'b0; bif.req_valid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bif.req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready c%0d got=%b exp=0000", c, bif.req_ready); end
      tick();
      n_checks++;
      if (bif.cdb_valid !== 2'b00 || bif.cdb_pd[0] !== '0)
        begin n_fail++; $display("FAIL idle_cdb c%0d got v=%b exp 00", c, bif.cdb_valid); end
    end
  endtask

  task automatic test_all_valid();
    set_payloads(); bif.req_valid = 4'b1111;
    #1;
    n_checks++;
    if (bif.req_ready !== 4'b0011) begin n_fail++; $display("FAIL all_c1_ready got=%b exp=0011", bif.req_ready); end
    tick();
    n_checks++;
    if (bif.cdb_valid !== 2'b11 || bif.cdb_rob_id[0] !== 3'd1 || bif.cdb_rob_id[1] !== 3'd2 ||
        bif.cdb_data[0] !== 32'h1000_0000 || bif.cdb_pd[1] !== 6'd11)
      begin n_fail++; $display("FAIL all_c1_cdb got v=%b r0=%0d r1=%0d exp v=11 r0=1 r1=2",
                               bif.cdb_valid, bif.cdb_rob_id[0], bif.cdb_rob_id[1]); end
    n_checks++;
    if (bif.req_ready !== 4'b1100) begin n_fail++; $display("FAIL all_c2_ready got=%b exp=1100", bif.req_ready); end
    tick();
    n_checks++;
    if (bif.cdb_valid !== 2'b11 || bif.cdb_rob_id[0] !== 3'd3 || bif.cdb_rob_id[1] !== 3'd4 ||
        bif.cdb_data[1] !== 32'h1000_0003)
      begin n_fail++; $display("FAIL all_c2_cdb got r0=%0d r1=%0d exp r0=3 r1=4",
                               bif.cdb_rob_id[0], bif.cdb_rob_id[1]); end
    bif.req_valid = 4'b0000;
  endtask

  task automatic test_single();
    bif.req_valid = 4'b0100; bif.req_pd[2] = 6'd17; bif.req_data[2] = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (bif.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", bif.req_ready); end
    tick();
    bif.req_valid = 4'b0000;
    n_checks++;
    if (bif.cdb_valid !== 2'b01 || bif.cdb_pd[0] !== 6'd17 || bif.cdb_data[0] !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL single_cdb got v=%b pd=%0d d=%h exp v=01 pd=17 d=deadbeef",
                               bif.cdb_valid, bif.cdb_pd[0], bif.cdb_data[0]); end
  endtask

  task automatic test_wrap();
    bif.req_valid = 4'b1001; bif.req_rob_id[3] = 3'd5; bif.req_rob_id[0] = 3'd2;
    #1;
    n_checks++;
    if (bif.req_ready !== 4'b1001) begin n_fail++; $display("FAIL wrap_ready got=%b exp=1001", bif.req_ready); end
    tick();
    n_checks++;
    if (bif.cdb_valid !== 2'b11 || bif.cdb_rob_id[0] !== 3'd5 || bif.cdb_rob_id[1] !== 3'd2)
      begin n_fail++; $display("FAIL wrap_cdb got r0=%0d r1=%0d exp r0=5 r1=2", bif.cdb_rob_id[0], bif.cdb_rob_id[1]); end
    set_payloads(); bif.req_valid = 4'b1111;
    #1;
    n_checks++;
    if (bif.req_ready !== 4'b0110) begin n_fail++; $display("FAIL wrap_ptr1_ready got=%b exp=0110", bif.req_ready); end
    tick();
    bif.req_valid = 4'b0000;
  endtask

  task automatic test_flush();
    set_payloads(); bif.req_valid = 4'b1111; flush = 1'b1;
    #1;
    n_checks++;
    if (bif.req_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_ready got=%b exp=0000", bif.req_ready); end
    tick();
    flush = 1'b0;
    n_checks++;
    if (bif.cdb_valid !== 2'b00) begin n_fail++; $display("FAIL flush_cdb got=%b exp=00", bif.cdb_valid); end
    #1;
    n_checks++;
    if (bif.req_ready !== 4'b1001) begin n_fail++; $display("FAIL flush_resume_ready got=%b exp=1001", bif.req_ready); end
    tick();
    n_checks++;
    if (bif.cdb_rob_id[0] !== 3'd4 || bif.cdb_rob_id[1] !== 3'd1)
      begin n_fail++; $display("FAIL flush_resume_cdb got r0=%0d r1=%0d exp r0=4 r1=1", bif.cdb_rob_id[0], bif.cdb_rob_id[1]); end
    bif.req_valid = 4'b0000;
  endtask

  task automatic test_stall();
    logic [3:0] exp_rdy [10] = '{4'b0110, 4'b1001, 4'b1100, 4'b0011, 4'b1100,
                                 4'b0101, 4'b1001, 4'b0110, 4'b1001, 4'b1100};
    logic       r1_vld  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] missed;
    missed = '0;
    set_payloads();
    for (int c = 0; c < 10; c++) begin
      bif.req_valid = {2'b11, r1_vld[c], 1'b1};
      #1;
      n_checks++;
      if (bif.req_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL stall_ready c%0d got=%b exp=%b", c, bif.req_ready, exp_rdy[c]); end
      n_checks++;
      if ((bif.req_ready & ~bif.req_valid) !== 4'b0000)
        begin n_fail++; $display("FAIL stall_invalid_grant c%0d ready=%b valid=%b", c, bif.req_ready, bif.req_valid); end
      n_checks++;
      if ((missed & bif.req_valid & ~bif.req_ready) !== 4'b0000)
        begin n_fail++; $display("FAIL stall_fairness c%0d missed_twice=%b exp=0000", c, missed & bif.req_valid & ~bif.req_ready); end
      missed = bif.req_valid & ~bif.req_ready;
      tick();
      n_checks++;
      if (bif.cdb_valid !== 2'b11) begin n_fail++; $display("FAIL stall_cdb c%0d got=%b exp=11", c, bif.cdb_valid); end
    end
    bif.req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    set_payloads(); bif.req_valid = 4'b1111;
    #1;
    n_checks++;
    if (bif.req_ready !== 4'b0011) begin n_fail++; $display("FAIL mid_pre_ready got=%b exp=0011", bif.req_ready); end
    tick();
    rst = 1'b1; flush = 1'b1;
    #1;
    n_checks++;
    if (bif.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=0000", bif.req_ready); end
    tick();
    n_checks++;
    if (bif.cdb_valid !== 2'b00 || bif.cdb_data[0] !== 32'h0)
      begin n_fail++; $display("FAIL mid_rst_cdb got v=%b d0=%h exp v=00 d0=0", bif.cdb_valid, bif.cdb_data[0]); end
    rst = 1'b0; flush = 1'b0;
    #1;
    n_checks++;
    if (bif.req_ready !== 4'b0011) begin n_fail++; $display("FAIL mid_post_ready got=%b exp=0011", bif.req_ready); end
    tick();
    bif.req_valid = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_all_valid();
    test_single();
    test_wrap();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
